// File: rtl/periodic_serial_tx.sv
// periodic_serial_tx: periodic serial frame transmitter with an integrated shift register.
// While EN is high it sends one frame (MSG_W data bits, plus an optional parity bit)
// on state_out. It then idles for SB+1 cycles and repeats. In one-shot mode it sends
// only one frame per EN assertion.
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   EN                  enable, sampled on every rising edge
//   ONESHOT             1 = one frame per EN assertion (sampled at frame start)
//   msg [MSG_W]         message, latched at frame start
//   SB  [SB_W]          standby length (gap = SB+1 cycles), latched at gap start
//   state_send          high on the first bit cycle of each frame
//   state_out           serial data, 0 when no bit is being sent
//   busy                high on every bit cycle of a frame
//   done                one-cycle pulse on the first gap cycle
module periodic_serial_tx #(
    parameter int unsigned MSG_W      = 4,
    parameter int unsigned SB_W       = 4,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             ONESHOT,
    input  logic [MSG_W-1:0] msg,
    input  logic [SB_W-1:0]  SB,
    output logic             state_send,
    output logic             state_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned FRAME_LEN = MSG_W + (PARITY_EN ? 1 : 0);
    localparam int unsigned CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned GAP_W     = SB_W + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
    // Cycle index after which the parity bit goes out (only meaningful with parity).
    localparam logic [CNT_W-1:0] PAR_PREV = CNT_W'((FRAME_LEN >= 2) ? (FRAME_LEN - 2) : 0);

    typedef enum logic [1:0] {IDLE, SEND, GAP, HOLD} state_e;

    state_e             state_q, state_d;
    logic [MSG_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               parity_q, parity_d;
    logic               mode_q, mode_d;
    logic               armed_q, armed_d;
    logic               send_q, send_d;
    logic               out_q, out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               start_c;

    // First bit taken straight from msg on load; the remaining bits are parked in sr.
    logic               load_bit_c;
    logic [MSG_W-1:0]   load_sr_c;
    logic               head_c;
    logic [MSG_W-1:0]   shift_sr_c;

    assign load_bit_c = MSB_FIRST ? msg[MSG_W-1]  : msg[0];
    assign load_sr_c  = MSB_FIRST ? (msg << 1)    : (msg >> 1);
    assign head_c     = MSB_FIRST ? sr_q[MSG_W-1] : sr_q[0];
    assign shift_sr_c = MSB_FIRST ? (sr_q << 1)   : (sr_q >> 1);

    // State and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            parity_q <= 1'b0;
            mode_q   <= 1'b0;
            armed_q  <= 1'b1;
            send_q   <= 1'b0;
            out_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            parity_q <= parity_d;
            mode_q   <= mode_d;
            armed_q  <= armed_d;
            send_q   <= send_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic; output values are computed for the cycle that follows the edge
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        parity_d = parity_q;
        mode_d   = mode_q;
        armed_d  = armed_q;
        send_d   = 1'b0;
        out_d    = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        start_c  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (EN && armed_q) begin
                    start_c = 1'b1;
                end
            end
            SEND: begin
                if (cnt_q == LAST_BIT) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    gap_d   = {1'b0, SB};
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = CNT_W'(cnt_q + 1'b1);
                    busy_d = 1'b1;
                    if (PARITY_EN && (cnt_q == PAR_PREV)) begin
                        out_d = parity_q;
                    end else begin
                        out_d = head_c;
                        sr_d  = shift_sr_c;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    if (mode_q) begin
                        armed_d = 1'b0;
                        state_d = HOLD;
                    end else if (EN) begin
                        start_c = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = GAP_W'(gap_q - 1'b1);
                end
            end
            HOLD: begin
                if (!EN) begin
                    armed_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame start: latch message, mode and parity; drive the first bit right away
        if (start_c) begin
            state_d  = SEND;
            sr_d     = load_sr_c;
            cnt_d    = '0;
            mode_d   = ONESHOT;
            parity_d = (^msg) ^ PARITY_ODD;
            out_d    = load_bit_c;
            send_d   = 1'b1;
            busy_d   = 1'b1;
        end
    end

    assign state_send = send_q;
    assign state_out  = out_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_periodic_serial_tx.sv
// Directed testbench for periodic_serial_tx. It uses three instances:
//   u0: default parameters
//   u1: LSB first with even parity
//   u2: MSG_W=1
// Expected waveforms are written as strings, one character per cycle.
module tb_periodic_serial_tx;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    logic       en0 = 1'b0, on0 = 1'b0;
    logic [3:0] msg0 = '0, sb0 = '0;
    logic       s0, o0, b0, d0;

    logic       en1 = 1'b0, on1 = 1'b0;
    logic [3:0] msg1 = '0, sb1 = '0;
    logic       s1, o1, b1, d1;

    logic       en2 = 1'b0, on2 = 1'b0;
    logic [0:0] msg2 = '0;
    logic [3:0] sb2 = '0;
    logic       s2, o2, b2, d2;

    int errors = 0;
    int checks = 0;

    logic [3:0] ob [3];
    assign ob[0] = {d0, b0, o0, s0};
    assign ob[1] = {d1, b1, o1, s1};
    assign ob[2] = {d2, b2, o2, s2};

    always #5 CLK = ~CLK;

    periodic_serial_tx u0 (
        .CLK(CLK), .RST(RST), .EN(en0), .ONESHOT(on0), .msg(msg0), .SB(sb0),
        .state_send(s0), .state_out(o0), .busy(b0), .done(d0)
    );

    periodic_serial_tx #(.MSG_W(4), .SB_W(4), .MSB_FIRST(1'b0), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u1 (
        .CLK(CLK), .RST(RST), .EN(en1), .ONESHOT(on1), .msg(msg1), .SB(sb1),
        .state_send(s1), .state_out(o1), .busy(b1), .done(d1)
    );

    periodic_serial_tx #(.MSG_W(1), .SB_W(4)) u2 (
        .CLK(CLK), .RST(RST), .EN(en2), .ONESHOT(on2), .msg(msg2), .SB(sb2),
        .state_send(s2), .state_out(o2), .busy(b2), .done(d2)
    );

    function automatic string z(input int n);
        string s;
        s = "";
        for (int k = 0; k < n; k++) s = {s, "0"};
        return s;
    endfunction

    task automatic chk(input string tag, input int i, input string nm, input logic got, input byte e);
        logic exp_b;
        exp_b = (e == "1");
        checks++;
        assert (got === exp_b) else begin
            errors++;
            $error("FAIL %s[%0d].%s got=%b exp=%b", tag, i, nm, got, exp_b);
        end
    endtask

    // One character per cycle. The check runs 1 time unit after each rising edge.
    task automatic check_seq(input int sel, input string tag, input string eo, input string es,
                             input string eb, input string ed);
        for (int i = 0; i < eo.len(); i++) begin
            @(posedge CLK);
            #1;
            chk(tag, i, "send", ob[sel][0], es[i]);
            chk(tag, i, "out",  ob[sel][1], eo[i]);
            chk(tag, i, "busy", ob[sel][2], eb[i]);
            chk(tag, i, "done", ob[sel][3], ed[i]);
        end
    endtask

    initial begin
        // Reset state on all instances
        check_seq(0, "rst0", "00", "00", "00", "00");
        check_seq(1, "rst1", "00", "00", "00", "00");
        check_seq(2, "rst2", "00", "00", "00", "00");
        RST = 1'b0;
        check_seq(0, "idle0", "00", "00", "00", "00");

        // Periodic frame: msg=1010, SB=2, period 7
        msg0 = 4'b1010; sb0 = 4'd2; on0 = 1'b0; en0 = 1'b1;
        check_seq(0, "per", "10100001010000", "10000001000000",
                            "11110001111000", "00001000000100");
        en0 = 1'b0;
        check_seq(0, "per_idle", "000", "000", "000", "000");

        // LSB first with even parity: msg=0111 -> 1,1,1,0,p=1, then a 1-cycle gap
        msg1 = 4'b0111; sb1 = 4'd0; en1 = 1'b1;
        check_seq(1, "par", "111010111010", "100000100000",
                            "111110111110", "000001000001");
        en1 = 1'b0;
        check_seq(1, "par_idle", "00", "00", "00", "00");

        // One-shot: msg=1100, SB=3, EN held high for 30 cycles
        msg0 = 4'b1100; sb0 = 4'd3; on0 = 1'b1; en0 = 1'b1;
        check_seq(0, "os1", {"1100", z(26)}, {"1", z(29)}, {"1111", z(26)}, {"00001", z(25)});
        en0 = 1'b0;
        check_seq(0, "os_low", "0", "0", "0", "0");
        en0 = 1'b1;
        check_seq(0, "os2", {"1100", z(16)}, {"1", z(19)}, {"1111", z(16)}, {"00001", z(15)});
        en0 = 1'b0; on0 = 1'b0;
        check_seq(0, "os_idle", "00", "00", "00", "00");

        // EN dropped on the 2nd bit cycle: the frame and gap still complete
        msg0 = 4'b1111; sb0 = 4'd2; en0 = 1'b1;
        check_seq(0, "mid0", "1", "1", "1", "0");
        check_seq(0, "mid1", "1", "0", "1", "0");
        en0 = 1'b0;
        msg0 = 4'b0000;
        check_seq(0, "mid2", "11000000", "00000000", "11000000", "00100000");

        // Asynchronous reset during bit 2
        msg0 = 4'b1111; en0 = 1'b1;
        check_seq(0, "ar_pre", "111", "100", "111", "000");
        #2;
        RST = 1'b1;
        #1;
        chk("ar_async", 0, "send", s0, "0");
        chk("ar_async", 0, "out",  o0, "0");
        chk("ar_async", 0, "busy", b0, "0");
        chk("ar_async", 0, "done", d0, "0");
        #1;
        RST = 1'b0;
        check_seq(0, "ar_post", "1111000", "1000000", "1111000", "0000100");
        en0 = 1'b0;
        check_seq(0, "ar_idle", "00", "00", "00", "00");

        // SB=4'hF gives a 16-cycle gap
        msg0 = 4'b1000; sb0 = 4'hF; en0 = 1'b1;
        check_seq(0, "sbmax", {"1000", z(16), "1"}, {"1", z(19), "1"},
                              {"1111", z(16), "1"}, {"0000", "1", z(16)});
        en0 = 1'b0;
        check_seq(0, "sbmax_end", z(24), z(24), {"111", z(21)}, {"000", "1", z(20)});

        // MSG_W=1, msg=1, SB=0: alternating 1,0
        msg2 = 1'b1; sb2 = 4'd0; en2 = 1'b1;
        check_seq(2, "w1", "101010", "101010", "101010", "010101");
        en2 = 1'b0;
        check_seq(2, "w1_idle", "00", "00", "00", "00");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
